// File: rtl/stopwatch_if.sv
// Signal bundle between the stopwatch control FSM and its environment:
// rate tick, raw buttons and terminal flag in; counter strobes and state out.
interface stopwatch_if;
  logic       tick;
  logic       btn_start;
  logic       btn_reset;
  logic       btn_lap;
  logic       cnt_max;
  logic       count_pulse;
  logic       cnt_clr;
  logic       freeze;
  logic [2:0] state;

  modport master (
    output tick, btn_start, btn_reset, btn_lap, cnt_max,
    input  count_pulse, cnt_clr, freeze, state
  );

  modport slave (
    input  tick, btn_start, btn_reset, btn_lap, cnt_max,
    output count_pulse, cnt_clr, freeze, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces start/reset/lap buttons and sequences
// the time counter (advance strobe, clear, lap display freeze).
module stopwatch_ctrl #(
  parameter int DEBOUNCE_LEN = 4
) (
  input logic        clk,
  input logic        rst_n,
  stopwatch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    DONE  = 3'd4
  } st_e;

  st_e  state_q;
  st_e  nxt;
  logic cnt_clr_q;
  logic freeze_q;
  logic counting;
  logic term;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {bus.btn_lap, bus.btn_reset, bus.btn_start};

  // Level flips only after DEBOUNCE_LEN identical samples
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DEBOUNCE_LEN-1:0] sh;
    logic                    lvl;
    logic                    prv;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh  <= '0;
        lvl <= 1'b0;
        prv <= 1'b0;
      end else begin
        sh  <= {sh[DEBOUNCE_LEN-2:0], raw[i]};
        if (&sh)
          lvl <= 1'b1;
        else if (~|sh)
          lvl <= 1'b0;
        prv <= lvl;
      end
    end

    assign press[i] = lvl & ~prv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= nxt;
  end

  assign counting = (state_q == RUN) | (state_q == LAP);
  assign term     = bus.tick & bus.cnt_max & counting;

  always_comb begin
    nxt = state_q;
    if (press[1]) begin
      nxt = IDLE;
    end else if (term) begin
      nxt = DONE;
    end else if (press[0]) begin
      unique case (state_q)
        IDLE:    nxt = RUN;
        RUN:     nxt = PAUSE;
        PAUSE:   nxt = RUN;
        LAP:     nxt = PAUSE;
        default: nxt = state_q;
      endcase
    end else if (press[2]) begin
      unique case (state_q)
        RUN:     nxt = LAP;
        LAP:     nxt = RUN;
        default: nxt = state_q;
      endcase
    end
  end

  always_comb begin
    bus.count_pulse = bus.tick & counting & ~bus.cnt_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clr_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      cnt_clr_q <= press[1];
      freeze_q  <= (nxt == LAP);
    end
  end

  assign bus.cnt_clr = cnt_clr_q;
  assign bus.freeze  = freeze_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (DEBOUNCE_LEN=4).
// Inputs change just after the falling edge; outputs are checked there too.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stopwatch_if sw ();

  stopwatch_ctrl #(.DEBOUNCE_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_chk(input string tag, input int exp);
    sw.tick = 1'b1;
    #1;
    chk(tag, int'(sw.count_pulse), exp);
    @(negedge clk);
    sw.tick = 1'b0;
  endtask

  // which: 0=start 1=reset 2=lap; held long enough for one press
  task automatic press(input int which);
    if (which == 0) sw.btn_start = 1'b1;
    if (which == 1) sw.btn_reset = 1'b1;
    if (which == 2) sw.btn_lap   = 1'b1;
    cyc(6);
    sw.btn_start = 1'b0;
    sw.btn_reset = 1'b0;
    sw.btn_lap   = 1'b0;
    cyc(5);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sw.tick = 1'b0;
    sw.btn_start = 1'b0;
    sw.btn_reset = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.cnt_max   = 1'b0;

    // reset state
    cyc(3);
    chk("rst_state", int'(sw.state), 0);
    chk("rst_clr", int'(sw.cnt_clr), 0);
    chk("rst_freeze", int'(sw.freeze), 0);
    tick_chk("rst_tick", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(9);
      tick_chk("idle_tick", 0);
    end
    chk("idle_clr", int'(sw.cnt_clr), 0);

    // start latency: edge k samples 1, state moves at k+5
    sw.btn_start = 1'b1;
    cyc(5);
    chk("start_early", int'(sw.state), 0);
    cyc(1);
    chk("start_run", int'(sw.state), 1);
    cyc(2);
    sw.btn_start = 1'b0;
    cyc(5);
    chk("start_hold", int'(sw.state), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(9);
      tick_chk("run_tick", 1);
    end
    #1;
    chk("run_notick", int'(sw.count_pulse), 0);
    press(0);
    chk("pause", int'(sw.state), 2);
    tick_chk("pause_tick", 0);

    // glitches then long hold
    sw.btn_start = 1'b1;
    cyc(3);
    sw.btn_start = 1'b0;
    cyc(1);
    sw.btn_start = 1'b1;
    cyc(1);
    sw.btn_start = 1'b0;
    cyc(1);
    sw.btn_start = 1'b1;
    cyc(1);
    sw.btn_start = 1'b0;
    cyc(6);
    chk("glitch", int'(sw.state), 2);
    sw.btn_start = 1'b1;
    cyc(200);
    chk("long_hold", int'(sw.state), 1);
    sw.btn_start = 1'b0;
    cyc(6);
    chk("release", int'(sw.state), 1);

    // lap behaviour
    press(2);
    chk("lap", int'(sw.state), 3);
    chk("lap_freeze", int'(sw.freeze), 1);
    tick_chk("lap_tick", 1);
    press(2);
    chk("lap_run", int'(sw.state), 1);
    chk("lap_unfreeze", int'(sw.freeze), 0);
    press(2);
    chk("lap2", int'(sw.state), 3);
    press(0);
    chk("lap_pause", int'(sw.state), 2);
    chk("lap_pause_frz", int'(sw.freeze), 0);

    // terminal count
    press(0);
    chk("resume", int'(sw.state), 1);
    sw.cnt_max = 1'b1;
    tick_chk("max_tick", 0);
    chk("done", int'(sw.state), 4);
    sw.cnt_max = 1'b0;
    press(0);
    chk("done_start", int'(sw.state), 4);
    press(2);
    chk("done_lap", int'(sw.state), 4);
    sw.btn_reset = 1'b1;
    cyc(5);
    chk("clr_early", int'(sw.cnt_clr), 0);
    chk("done_hold", int'(sw.state), 4);
    cyc(1);
    chk("rst_idle", int'(sw.state), 0);
    chk("clr_pulse", int'(sw.cnt_clr), 1);
    cyc(1);
    chk("clr_one", int'(sw.cnt_clr), 0);
    sw.btn_reset = 1'b0;
    cyc(5);

    // reset beats start in the same cycle
    press(0);
    press(0);
    chk("pause2", int'(sw.state), 2);
    sw.btn_reset = 1'b1;
    sw.btn_start = 1'b1;
    cyc(6);
    chk("both_idle", int'(sw.state), 0);
    chk("both_clr", int'(sw.cnt_clr), 1);
    cyc(1);
    chk("both_norun", int'(sw.state), 0);
    chk("both_clr_end", int'(sw.cnt_clr), 0);
    sw.btn_reset = 1'b0;
    sw.btn_start = 1'b0;
    cyc(5);

    // reset press while already idle still clears
    sw.btn_reset = 1'b1;
    cyc(6);
    chk("idle_rst_clr", int'(sw.cnt_clr), 1);
    sw.btn_reset = 1'b0;
    cyc(5);

    // tick in the same cycle as leaving RUN
    press(0);
    chk("run3", int'(sw.state), 1);
    sw.btn_start = 1'b1;
    cyc(5);
    sw.tick = 1'b1;
    #1;
    chk("edge_tick", int'(sw.count_pulse), 1);
    chk("edge_state", int'(sw.state), 1);
    @(negedge clk);
    sw.tick = 1'b0;
    chk("edge_pause", int'(sw.state), 2);
    sw.btn_start = 1'b0;
    cyc(5);

    // rst_n during a held press restarts the debouncer
    sw.btn_start = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst", int'(sw.state), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    chk("rst_mid_early", int'(sw.state), 0);
    cyc(1);
    chk("rst_mid_run", int'(sw.state), 1);
    sw.btn_start = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
